bus_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the coherent bus controller between the NCPUS L1 caches.
- Grants exactly one cache per bus transaction and holds the grant until the bus controller signals completion.
- Sits between the per-CPU cache request lines and the bus controller's transaction-start/done handshake.
- Includes a watchdog that aborts hung transactions and flags them.

---
 rtl/bus_rr_arbiter_pkg.sv | 16 +
 rtl/bus_rr_arbiter_if.sv | 27 ++
 rtl/bus_rr_arbiter_picker.sv | 33 +++
 rtl/bus_rr_arbiter.sv | 94 +++++++++
 tb/tb_bus_rr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and defaults for the coherent-bus round-robin arbiter.
// Imported by the interface, the priority picker and the arbiter top.
package bus_arb_pkg;

  localparam int NCPUS_DEFAULT   = 8;
  localparam int TIMEOUT_DEFAULT = 10000;
  localparam int CPU_ID_W        = $clog2(NCPUS_DEFAULT);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  typedef logic [CPU_ID_W-1:0] cpu_id_t;

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant and bus-controller handshake bundle between the L1 caches and the arbiter.
// The master modport is the arbiter's view; slave is the caches/bus-controller side.
interface bus_rr_arbiter_if import bus_arb_pkg::*; #(
  parameter int NCPUS    = NCPUS_DEFAULT,
  parameter int CPU_ID_W = $clog2(NCPUS)
) ();

  logic [NCPUS-1:0]    req;
  logic [NCPUS-1:0]    grant;
  logic                grant_valid;
  logic [CPU_ID_W-1:0] grant_id;
  logic                bus_start;
  logic                bus_done;
  logic                timeout_err;
  logic [CPU_ID_W-1:0] timeout_id;

  modport master (
    input  req, bus_done,
    output grant, grant_valid, grant_id, bus_start, timeout_err, timeout_id
  );

  modport slave (
    output req, bus_done,
    input  grant, grant_valid, grant_id, bus_start, timeout_err, timeout_id
  );

endinterface

// File: rtl/bus_rr_arbiter_picker.sv
// Combinational round-robin picker: first set request scanning upward from rr_ptr,
// wrapping from NCPUS-1 back to 0.
module rr_priority_picker import bus_arb_pkg::*; #(
  parameter int NCPUS    = NCPUS_DEFAULT,
  parameter int CPU_ID_W = $clog2(NCPUS)
) (
  input  logic [NCPUS-1:0]    req,
  input  logic [CPU_ID_W-1:0] rr_ptr,
  output logic [CPU_ID_W-1:0] winner,
  output logic                any_req
);

  // Index of the i-th candidate after rr_ptr, modulo NCPUS (NCPUS need not be a power of 2).
  function automatic logic [CPU_ID_W-1:0] slot(input logic [CPU_ID_W-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= NCPUS) s = s - NCPUS;
    return CPU_ID_W'(s);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    winner  = '0;
    any_req = 1'b0;
    for (int i = 0; i < NCPUS; i++) begin
      if (!any_req && req[slot(rr_ptr, i)]) begin
        winner  = slot(rr_ptr, i);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner selection for the coherent bus: one grant per transaction, held until
// bus_done, with a watchdog that force-releases a hung owner and records it.
module bus_rr_arbiter import bus_arb_pkg::*; #(
  parameter int NCPUS    = NCPUS_DEFAULT,
  parameter int CPU_ID_W = $clog2(NCPUS),
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  bus_rr_arbiter_if.master  bus
);

  localparam int                  WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [0:0]          S_IDLE    = IDLE;
  localparam logic [0:0]          S_GRANTED = GRANTED;
  localparam logic [WD_W-1:0]     WD_FIRE   = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]     WD_MAX    = '1;
  localparam logic [CPU_ID_W-1:0] LAST_ID   = CPU_ID_W'(NCPUS - 1);
  localparam logic [NCPUS-1:0]    ONE       = NCPUS'(1);

  logic [0:0]          state;
  logic [CPU_ID_W-1:0] rr_ptr;
  logic [CPU_ID_W-1:0] winner;
  logic                any_req;
  logic [WD_W-1:0]     wd_cnt;
  logic                release_now;
  logic                wd_fire;

  rr_priority_picker #(
    .NCPUS    (NCPUS),
    .CPU_ID_W (CPU_ID_W)
  ) u_picker (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // bus_done takes priority over the watchdog: a transaction finishing on the last
  // allowed cycle is a normal completion, not an error.
  assign release_now = (state == S_GRANTED) && (bus.bus_done || (wd_cnt == WD_FIRE));
  assign wd_fire     = (state == S_GRANTED) && !bus.bus_done && (wd_cnt == WD_FIRE);

  // NOTE: reset is synchronous and active-high here because the bus controller shares RST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      wd_cnt          <= '0;
      bus.grant       <= '0;
      bus.grant_valid <= 1'b0;
      bus.grant_id    <= '0;
      bus.bus_start   <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.timeout_id  <= '0;
    end else begin
      bus.bus_start <= 1'b0;
      case (state)
        S_IDLE: begin
          wd_cnt <= '0;
          if (any_req) begin
            state           <= S_GRANTED;
            bus.grant       <= ONE << winner;
            bus.grant_valid <= 1'b1;
            bus.grant_id    <= winner;
            bus.bus_start   <= 1'b1;
          end
        end
        default: begin
          if (release_now) begin
            state           <= S_IDLE;
            wd_cnt          <= '0;
            bus.grant       <= '0;
            bus.grant_valid <= 1'b0;
            bus.grant_id    <= '0;
            rr_ptr          <= (bus.grant_id == LAST_ID) ? '0 : bus.grant_id + 1'b1;
            if (wd_fire) begin
              bus.timeout_err <= 1'b1;
              bus.timeout_id  <= bus.grant_id;
            end
          end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(bus.grant));
  a_valid_match:  assert property (@(posedge CLK) disable iff (RST) bus.grant_valid == (|bus.grant));
  a_start_valid:  assert property (@(posedge CLK) disable iff (RST) bus.bus_start |-> bus.grant_valid);
  a_done_granted: assert property (@(posedge CLK) disable iff (RST) bus.bus_done |-> (state == S_GRANTED));

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: inputs driven and outputs sampled on the falling edge.
// NCPUS=8, TIMEOUT=16 so the watchdog fires within a short run.
module tb_bus_rr_arbiter;
  import bus_arb_pkg::*;

  localparam int NC = 8;
  localparam int TO = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  bus_rr_arbiter_if #(.NCPUS(NC)) bus ();

  bus_rr_arbiter #(.NCPUS(NC), .TIMEOUT(TO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    RST          = 1'b1;
    bus.req      = '0;
    bus.bus_done = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic pulse_done();
    bus.bus_done = 1'b1;
    tick();
    bus.bus_done = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({bus.grant, bus.grant_valid, bus.bus_start} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_grant: grant=%b valid=%b start=%b required all 0",
               bus.grant, bus.grant_valid, bus.bus_start);
    end
    n_tests++;
    if ({bus.grant_id, bus.timeout_err, bus.timeout_id} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ids: grant_id=%0d timeout_err=%b timeout_id=%0d required 0",
               bus.grant_id, bus.timeout_err, bus.timeout_id);
    end
  endtask

  task automatic test_single();
    apply_reset();
    bus.req = 8'b0000_0100;
    tick();
    n_tests++;
    if ({bus.grant, bus.grant_id, bus.grant_valid, bus.bus_start} !== {8'b0000_0100, 3'd2, 2'b11}) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b id=%0d valid=%b start=%b required 00000100/2/1/1",
               bus.grant, bus.grant_id, bus.grant_valid, bus.bus_start);
    end
    bus.req = '0;
    tick();
    n_tests++;
    if ({bus.grant, bus.bus_start} !== {8'b0000_0100, 1'b0}) begin
      n_fail++;
      $display("FAIL single_hold: grant=%b start=%b required 00000100/0", bus.grant, bus.bus_start);
    end
    tick();
    tick();
    pulse_done();
    n_tests++;
    if ({bus.grant, bus.grant_valid, bus.grant_id} !== 12'b0) begin
      n_fail++;
      $display("FAIL single_release: grant=%b valid=%b id=%0d required 0",
               bus.grant, bus.grant_valid, bus.grant_id);
    end
    n_tests++;
    if (dut.rr_ptr !== 3'd3) begin
      n_fail++;
      $display("FAIL single_ptr: rr_ptr=%0d required 3", dut.rr_ptr);
    end
  endtask

  task automatic test_all_req();
    cpu_id_t    exp_id;
    logic [7:0] exp_g;
    apply_reset();
    bus.req = 8'hFF;
    for (int k = 0; k <= NC; k++) begin
      exp_id = cpu_id_t'(k % NC);
      exp_g  = 8'h01 << exp_id;
      tick();
      n_tests++;
      if ({bus.grant, bus.grant_id, bus.bus_start} !== {exp_g, exp_id, 1'b1}) begin
        n_fail++;
        $display("FAIL all_req_grant[%0d]: grant=%b id=%0d start=%b required %b/%0d/1",
                 k, bus.grant, bus.grant_id, bus.bus_start, exp_g, exp_id);
      end
      tick();
      pulse_done();
      if (k == NC) bus.req = '0;
      n_tests++;
      if (bus.grant_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL all_req_gap[%0d]: grant_valid=%b required 0", k, bus.grant_valid);
      end
    end
  endtask

  task automatic test_wrap_skip();
    apply_reset();
    bus.req = 8'b0010_0000;
    tick();
    bus.req = '0;
    tick();
    pulse_done();
    n_tests++;
    if (dut.rr_ptr !== 3'd6) begin
      n_fail++;
      $display("FAIL wrap_setup_ptr: rr_ptr=%0d required 6", dut.rr_ptr);
    end
    bus.req = 8'b0010_0010;
    tick();
    n_tests++;
    if (bus.grant_id !== 3'd1) begin
      n_fail++;
      $display("FAIL wrap_winner: grant_id=%0d required 1", bus.grant_id);
    end
    bus.req = '0;
    pulse_done();
    bus.req = 8'b0010_0000;
    tick();
    n_tests++;
    if ({bus.grant, bus.grant_id} !== {8'b0010_0000, 3'd5}) begin
      n_fail++;
      $display("FAIL skip_winner: grant=%b id=%0d required 00100000/5", bus.grant, bus.grant_id);
    end
    bus.req = '0;
    pulse_done();
  endtask

  // Counts observed grant cycles (including the grant cycle itself) until release.
  task automatic wait_release(output int held);
    held = 1;
    for (int i = 0; i < 40 && bus.grant_valid; i++) begin
      tick();
      if (bus.grant_valid) held++;
    end
  endtask

  task automatic test_watchdog();
    int held;
    apply_reset();
    bus.req = 8'b0000_1000;
    tick();
    bus.req = '0;
    wait_release(held);
    n_tests++;
    if (held !== TO) begin
      n_fail++;
      $display("FAIL wd_hold_cycles: held=%0d required %0d", held, TO);
    end
    n_tests++;
    if ({bus.timeout_err, bus.timeout_id, bus.grant_valid} !== {1'b1, 3'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL wd_fire: err=%b id=%0d valid=%b required 1/3/0",
               bus.timeout_err, bus.timeout_id, bus.grant_valid);
    end
    bus.req = 8'b0000_0001;
    tick();
    bus.req = '0;
    tick();
    pulse_done();
    n_tests++;
    if ({bus.timeout_err, bus.timeout_id} !== {1'b1, 3'd3}) begin
      n_fail++;
      $display("FAIL wd_sticky: err=%b id=%0d required 1/3", bus.timeout_err, bus.timeout_id);
    end
    bus.req = 8'b0100_0000;
    tick();
    bus.req = '0;
    wait_release(held);
    n_tests++;
    if ({bus.timeout_err, bus.timeout_id} !== {1'b1, 3'd6}) begin
      n_fail++;
      $display("FAIL wd_overwrite: err=%b id=%0d required 1/6", bus.timeout_err, bus.timeout_id);
    end
    apply_reset();
    bus.req = 8'b0000_1000;
    tick();
    bus.req = '0;
    repeat (TO - 1) tick();
    n_tests++;
    if (bus.grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_race_hold: grant_valid=%b required 1", bus.grant_valid);
    end
    pulse_done();
    n_tests++;
    if ({bus.grant_valid, bus.timeout_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL wd_done_wins: valid=%b err=%b required 0/0", bus.grant_valid, bus.timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.req = 8'b0001_0000;
    tick();
    bus.req = '0;
    pulse_done();
    bus.req = 8'b0001_0000;
    tick();
    bus.req = '0;
    RST     = 1'b1;
    tick();
    RST     = 1'b0;
    bus.req = 8'h30;
    n_tests++;
    if ({bus.grant, bus.grant_valid, bus.grant_id, bus.bus_start} !== 13'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: grant=%b valid=%b id=%0d start=%b required 0",
               bus.grant, bus.grant_valid, bus.grant_id, bus.bus_start);
    end
    tick();
    bus.req = '0;
    n_tests++;
    if ({bus.grant_id, bus.bus_start} !== {3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid_ptr: grant_id=%0d start=%b required 4/1", bus.grant_id, bus.bus_start);
    end
    pulse_done();
  endtask

  task automatic test_req_drop();
    apply_reset();
    bus.req = 8'b0000_0001;
    tick();
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({bus.grant, bus.grant_valid, bus.bus_start} !== {8'b0000_0001, 2'b10}) begin
        n_fail++;
        $display("FAIL req_drop_hold[%0d]: grant=%b valid=%b start=%b required 00000001/1/0",
                 i, bus.grant, bus.grant_valid, bus.bus_start);
      end
    end
    pulse_done();
    n_tests++;
    if (bus.grant !== 8'b0) begin
      n_fail++;
      $display("FAIL req_drop_release: grant=%b required 0", bus.grant);
    end
  endtask

  task automatic test_zero_latency();
    apply_reset();
    bus.req = 8'b0000_0010;
    tick();
    bus.req = '0;
    pulse_done();
    n_tests++;
    if ({bus.grant, bus.grant_valid, bus.timeout_err} !== 10'b0) begin
      n_fail++;
      $display("FAIL zero_latency: grant=%b valid=%b err=%b required 0",
               bus.grant, bus.grant_valid, bus.timeout_err);
    end
  endtask

  initial begin
    bus.req      = '0;
    bus.bus_done = 1'b0;
    test_reset();
    test_single();
    test_all_req();
    test_wrap_skip();
    test_watchdog();
    test_reset_mid();
    test_req_drop();
    test_zero_latency();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule
